// File: rtl/prng_pkg.sv
// Shared PRNG definitions: sequencer state encoding and default LCG constants.
package prng_pkg;

    localparam int PRNG_WIDTH     = 8;
    localparam int LCG_MUL        = 5;
    localparam int LCG_INC        = 3;
    localparam int LCG_MIN_LAT    = 2;
    localparam int LCG_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ADD  = 3'd2,
        HOLD = 3'd3,
        GAP  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/lcg_sequencer_mul.sv
// Shift-add multiplier: starts when en rises, done after WIDTH steps and held while en stays high.
// Dropping en clears the datapath, so a new operand pair needs en low for at least one cycle.
module lcg_sequencer_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic                 started;
    logic [CW-1:0]        bit_cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            started <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (!started) begin
            started <= 1'b1;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            bit_cnt <= '0;
        end else if (!done) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            // done lands on the same edge as the final partial product
            if (bit_cnt == LAST_STEP) begin
                done <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    assign result = acc;

endmodule

// File: rtl/lcg_sequencer.sv
// LCG controller x' = (MUL_CONST*x + INC_CONST) mod 2^WIDTH using an external multiplier.
// One word in flight; the next product is requested only after the current word is accepted.
module lcg_sequencer
    import prng_pkg::*;
#(
    parameter int WIDTH       = PRNG_WIDTH,
    parameter int MUL_CONST   = LCG_MUL,
    parameter int INC_CONST   = LCG_INC,
    parameter int MUL_MIN_LAT = LCG_MIN_LAT,
    parameter int CNT_WIDTH   = LCG_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [WIDTH-1:0]      seed_value,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    output logic                  mul_en,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_result,
    output logic [WIDTH-1:0]      rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic [CNT_WIDTH-1:0]  rnd_count
);

    localparam int LW = (MUL_MIN_LAT > 0) ? $clog2(MUL_MIN_LAT + 1) : 1;
    localparam logic [LW-1:0]    LAT_SAT = LW'(MUL_MIN_LAT);
    localparam logic [WIDTH-1:0] MUL_B   = WIDTH'(MUL_CONST);
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC_CONST);

    seq_state_t        state;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  p;
    logic [WIDTH-1:0]  next_x;
    logic [LW-1:0]     lat_cnt;
    logic              mul_en_q;
    logic              unused_hi;

    assign next_x    = p + INC_W;
    assign mul_a     = x;
    assign mul_b     = MUL_B;
    // reset pulls the enable down in the same cycle rather than at the next edge
    assign mul_en    = mul_en_q & ~rst;
    assign unused_hi = ^mul_result[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            p         <= '0;
            lat_cnt   <= '0;
            mul_en_q  <= 1'b0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
            rnd_count <= '0;
        end else if (seed_load) begin
            x         <= seed_value;
            lat_cnt   <= '0;
            mul_en_q  <= 1'b0;
            rnd_valid <= 1'b0;
            rnd_count <= '0;
            state     <= GAP;
        end else begin
            case (state)
                IDLE: begin
                    mul_en_q  <= 1'b0;
                    rnd_valid <= 1'b0;
                end
                GAP: begin
                    mul_en_q <= 1'b1;
                    lat_cnt  <= '0;
                    state    <= REQ;
                end
                REQ: begin
                    // a done seen before the latency floor may be left over from a previous product
                    if ((lat_cnt >= LAT_SAT) && mul_done) begin
                        p        <= mul_result[WIDTH-1:0];
                        mul_en_q <= 1'b0;
                        state    <= ADD;
                    end else if (lat_cnt < LAT_SAT) begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                ADD: begin
                    x         <= next_x;
                    rnd_data  <= next_x;
                    rnd_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rnd_ready) begin
                        rnd_valid <= 1'b0;
                        rnd_count <= rnd_count + CNT_WIDTH'(1);
                        state     <= GAP;
                    end
                end
                default: begin
                    mul_en_q  <= 1'b0;
                    rnd_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
